// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types, default sizes and helpers for conv_job_scheduler
// Purpose: scheduler FSM state type, default parameter values with the derived
//          beat/counter/pointer widths, and a one-hot to index helper.
// Ports:   none (package)
package conv_sched_pkg;

    localparam int N_DEF = 2;
    localparam int X_DEF = 16;
    localparam int F_DEF = 6;
    localparam int W_DEF = 16;

    localparam int OUT_BEATS = X_DEF - F_DEF + 1;
    localparam int CNT_W     = $clog2(X_DEF);
    localparam int PTR_W     = (N_DEF > 1) ? $clog2(N_DEF) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOAD,
        UNLOAD
    } state_e;

    // Up to 8 requesters; callers zero-extend their grant vector to 8 bits.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: returns the first set request at or above ptr_i, wrapping around.
// Ports:   req_i   [N]     request vector
//          ptr_i   [PTR_W] index with highest priority
//          pick_o  [N]     one-hot winner (0 when no request)
//          valid_o         any request present
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o,
    output logic             valid_o
);

    int idx;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// rtl/conv_job_scheduler.sv - round-robin job scheduler sharing one conv engine
// Purpose: grants a single streaming convolution engine to one of N requesters
//          for a whole job (X input beats, then X-F+1 output beats), then
//          rotates priority. Forwarding is purely combinational.
// Ports:   clk, reset (async, active high)
//          req_x_data/valid/ready  per-requester input streams
//          req_y_data (broadcast), req_y_valid/ready per-requester outputs
//          eng_x_* / eng_y_*       engine side streams
//          grant, busy, jobs_done, protocol_err status
module conv_job_scheduler
    import conv_sched_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int X = X_DEF,
    parameter int F = F_DEF,
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] req_x_data,
    input  logic [N-1:0]   req_x_valid,
    output logic [N-1:0]   req_x_ready,
    output logic [W-1:0]   req_y_data,
    output logic [N-1:0]   req_y_valid,
    input  logic [N-1:0]   req_y_ready,
    output logic [W-1:0]   eng_x_data,
    output logic           eng_x_valid,
    input  logic           eng_x_ready,
    input  logic [W-1:0]   eng_y_data,
    input  logic           eng_y_valid,
    output logic           eng_y_ready,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [15:0]    jobs_done,
    output logic           protocol_err
);

    localparam int CNT_BITS = $clog2(X);
    localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_BITS-1:0] IN_LAST  = CNT_BITS'(X - 1);
    localparam logic [CNT_BITS-1:0] OUT_LAST = CNT_BITS'(X - F);

    state_e              state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic [PTR_BITS-1:0] ptr_q, ptr_d, ptr_next;
    logic [CNT_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;
    logic [15:0]         jobs_q, jobs_d;
    logic                err_q, err_d;

    logic [N-1:0] pick;
    logic         pick_valid;
    logic [7:0]   grant_ext;
    logic [2:0]   owner_idx;
    logic         x_beat, y_beat;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_BITS)
    ) u_rr_pick (
        .req_i   (req_x_valid),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        grant_ext         = '0;
        grant_ext[N-1:0]  = grant_q;
    end

    assign owner_idx = onehot_to_idx(grant_ext);
    // Next owner after the current one gets top priority.
    assign ptr_next  = (owner_idx == 3'(N - 1)) ? '0 : PTR_BITS'(owner_idx + 3'd1);

    // Stream forwarding: only the owner's lanes are connected, everything else idles at 0.
    always_comb begin
        req_x_ready = '0;
        req_y_valid = '0;
        req_y_data  = '0;
        eng_x_data  = '0;
        eng_x_valid = 1'b0;
        eng_y_ready = 1'b0;
        if (state_q == LOAD) begin
            eng_x_valid = |(req_x_valid & grant_q);
            req_x_ready = grant_q & {N{eng_x_ready}};
            for (int i = 0; i < N; i++) begin
                if (grant_q[i]) begin
                    eng_x_data = req_x_data[i*W +: W];
                end
            end
        end
        if (state_q == UNLOAD) begin
            req_y_valid = grant_q & {N{eng_y_valid}};
            req_y_data  = eng_y_data;
            eng_y_ready = |(req_y_ready & grant_q);
        end
    end

    assign x_beat = eng_x_valid & eng_x_ready;
    assign y_beat = eng_y_valid & eng_y_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        jobs_d    = jobs_q;
        // The engine may only talk on y while unloading and only accept x outside it.
        err_d     = err_q | (eng_y_valid & (state_q != UNLOAD))
                          | (eng_x_ready & (state_q == UNLOAD));
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (x_beat) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = UNLOAD;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            UNLOAD: begin
                if (y_beat) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        jobs_d    = jobs_q + 16'd1;
                        ptr_d     = ptr_next;
                        grant_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            jobs_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            jobs_q    <= jobs_d;
            err_q     <= err_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign jobs_done    = jobs_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb/tb_conv_job_scheduler.sv - self-checking bench for conv_job_scheduler
module tb_conv_job_scheduler;

    localparam int N   = 2;
    localparam int X   = 16;
    localparam int F   = 6;
    localparam int W   = 16;
    localparam int OUT = X - F + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] req_x_data;
    logic [N-1:0]   req_x_valid, req_x_ready;
    logic [W-1:0]   req_y_data;
    logic [N-1:0]   req_y_valid, req_y_ready;
    logic [W-1:0]   eng_x_data;
    logic           eng_x_valid, eng_x_ready;
    logic [W-1:0]   eng_y_data;
    logic           eng_y_valid, eng_y_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [15:0]    jobs_done;
    logic           protocol_err;

    always #5 clk = ~clk;

    conv_job_scheduler #(.N(N), .X(X), .F(F), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_x_data   (req_x_data),
        .req_x_valid  (req_x_valid),
        .req_x_ready  (req_x_ready),
        .req_y_data   (req_y_data),
        .req_y_valid  (req_y_valid),
        .req_y_ready  (req_y_ready),
        .eng_x_data   (eng_x_data),
        .eng_x_valid  (eng_x_valid),
        .eng_x_ready  (eng_x_ready),
        .eng_y_data   (eng_y_data),
        .eng_y_valid  (eng_y_valid),
        .eng_y_ready  (eng_y_ready),
        .grant        (grant),
        .busy         (busy),
        .jobs_done    (jobs_done),
        .protocol_err (protocol_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: job phase (0 idle, 1 settle, 2 load, 3 unload), owner, beats, ptr
    int   m_phase, m_owner, m_ptr, m_in, m_out, m_jobs;
    logic m_err;

    // Requesters and engine as seen by the bench
    int           x_left [N];
    logic [W-1:0] x_words[N][X];
    int           e_got, e_sent;
    logic [W-1:0] y_words[OUT];

    // Scenario knobs
    logic rnd, traffic, force_yv;
    int   drop_req, drop_beat, drop_left;
    int   ystall_at, ystall_left;

    // Observations of the DUT
    int           obs_x, obs_y;
    logic [N-1:0] last_grant;
    logic [N-1:0] obs_order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_job(input int i, input logic ones);
        x_left[i] = X;
        for (int k = 0; k < X; k++) begin
            x_words[i][k] = ones ? W'(1) : W'($urandom);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = -1; m_ptr = 0; m_in = 0; m_out = 0; m_jobs = 0; m_err = 1'b0;
        e_got = 0; e_sent = 0;
        for (int i = 0; i < N; i++) x_left[i] = 0;
        drop_req = -1; drop_left = 0; ystall_at = -1; ystall_left = 0; force_yv = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_x_ready"}, req_x_ready, 0);
        check({tag, "_eng_x_valid"}, eng_x_valid, 0);
        check({tag, "_eng_x_data"}, eng_x_data, 0);
        check({tag, "_req_y_valid"}, req_y_valid, 0);
        check({tag, "_req_y_data"}, req_y_data, 0);
        check({tag, "_eng_y_ready"}, eng_y_ready, 0);
        check({tag, "_jobs_done"}, jobs_done, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_x_valid = '0; req_x_data = '0; req_y_ready = '0;
        eng_x_ready = 1'b0; eng_y_valid = 1'b0; eng_y_data = '0;
        model_reset();
        @(posedge clk); #1;
        check_idle_outputs("reset");
        check("reset_protocol_err", protocol_err, 0);
        reset = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic tick();
        logic [N-1:0] own;
        logic         v, ld, ul, xv, yr, xbeat, ybeat;
        int           j;
        own = '0;
        if (m_owner >= 0) own[m_owner] = 1'b1;
        if (traffic) begin
            for (int i = 0; i < N; i++) begin
                if (x_left[i] == 0 && $urandom_range(3) == 0) new_job(i, 1'b0);
            end
        end
        for (int i = 0; i < N; i++) begin
            v = (x_left[i] > 0);
            if (rnd && $urandom_range(4) == 0) v = 1'b0;
            if (i == drop_req && m_phase == 2 && m_owner == i && m_in == drop_beat && drop_left > 0) begin
                v = 1'b0;
                drop_left--;
            end
            req_x_valid[i] = v;
            req_x_data[i*W +: W] = (x_left[i] > 0) ? x_words[i][X - x_left[i]] : W'($urandom);
            req_y_ready[i] = rnd ? ($urandom_range(2) != 0) : 1'b1;
        end
        if (m_phase == 3 && ystall_left > 0 && m_out == ystall_at) begin
            req_y_ready = req_y_ready & ~own;
            ystall_left--;
        end
        eng_x_ready = (e_got < X) ? (rnd ? ($urandom_range(1) == 1) : 1'b1) : 1'b0;
        eng_y_valid = (e_got == X && e_sent < OUT) ? (rnd ? ($urandom_range(1) == 1) : 1'b1) : 1'b0;
        eng_y_data  = (e_got == X && e_sent < OUT) ? y_words[e_sent] : W'($urandom);
        if (force_yv && m_phase == 2) eng_y_valid = 1'b1;
        #1;
        ld    = (m_phase == 2);
        ul    = (m_phase == 3);
        xv    = ld && |(req_x_valid & own);
        yr    = ul && |(req_y_ready & own);
        xbeat = xv && eng_x_ready;
        ybeat = ul && eng_y_valid && yr;
        check("grant", grant, own);
        check("grant_onehot0", $onehot0(grant), 1);
        check("busy", busy, m_phase != 0);
        check("req_x_ready", req_x_ready, ld ? (own & {N{eng_x_ready}}) : '0);
        check("eng_x_valid", eng_x_valid, xv);
        check("eng_y_ready", eng_y_ready, yr);
        check("req_y_valid", req_y_valid, ul ? (own & {N{eng_y_valid}}) : '0);
        check("jobs_done", jobs_done, 16'(m_jobs));
        check("protocol_err", protocol_err, m_err);
        if (xbeat) check("eng_x_data", eng_x_data, x_words[m_owner][m_in]);
        else if (!ld) check("eng_x_data_idle", eng_x_data, 0);
        if (ybeat) check("req_y_data", req_y_data, y_words[m_out]);
        else if (!ul) check("req_y_data_idle", req_y_data, 0);
        obs_x += int'(eng_x_valid & eng_x_ready);
        obs_y += int'(|(req_y_valid & req_y_ready));
        if (grant != '0 && grant != last_grant) obs_order.push_back(grant);
        last_grant = grant;
        // Advance the reference model on the coming edge.
        if ((eng_y_valid && m_phase != 3) || (eng_x_ready && m_phase == 3)) m_err = 1'b1;
        case (m_phase)
            0: begin
                for (int k = N - 1; k >= 0; k--) begin
                    j = (m_ptr + k) % N;
                    if (req_x_valid[j]) m_owner = j;
                end
                if (|req_x_valid) m_phase = 1;
            end
            1: m_phase = 2;
            2: if (xbeat) begin
                x_left[m_owner]--;
                e_got++;
                if (m_in == X - 1) begin
                    m_in = 0;
                    m_phase = 3;
                    for (int k = 0; k < OUT; k++) y_words[k] = W'($urandom);
                end else m_in++;
            end
            default: if (ybeat) begin
                e_sent++;
                if (m_out == OUT - 1) begin
                    m_out = 0;
                    m_jobs++;
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_phase = 0;
                    e_got = 0;
                    e_sent = 0;
                end else m_out++;
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic run_until_jobs(input int target, input int budget);
        int c;
        c = 0;
        while (m_jobs < target && c < budget) begin
            tick();
            c++;
        end
        check("jobs_done_end", jobs_done, target);
    endtask

    task automatic run_until_load(input int beat, input int budget);
        int c;
        c = 0;
        while (!(m_phase == 2 && m_in == beat) && c < budget) begin
            tick();
            c++;
        end
    endtask

    initial begin
        rnd = 1'b0; traffic = 1'b0; last_grant = '0;
        do_reset();

        // Single requester, all-ones data
        new_job(0, 1'b1); obs_x = 0; obs_y = 0;
        run_until_jobs(1, 200);
        check("s1_x_beats", obs_x, 16);
        check("s1_y_beats", obs_y, 11);
        check("s1_grant_after", grant, 0);

        // Simultaneous requests after reset: 0 first, then 1
        do_reset(); obs_order.delete(); last_grant = '0;
        new_job(0, 1'b0); new_job(1, 1'b0);
        run_until_jobs(2, 300);
        check("s2_order_len", obs_order.size(), 2);
        check("s2_first", obs_order.size() > 0 ? obs_order[0] : '0, 2'b01);
        check("s2_second", obs_order.size() > 1 ? obs_order[1] : '0, 2'b10);

        // Owner stalls for 5 cycles at beat 7 while requester 1 waits
        new_job(0, 1'b0); new_job(1, 1'b0);
        drop_req = 0; drop_beat = 7; drop_left = 5; obs_x = 0;
        run_until_jobs(4, 400);
        check("s3_x_beats", obs_x, 32);

        // Owner output backpressure for 3 cycles mid-unload
        new_job(1, 1'b0); ystall_at = 4; ystall_left = 3; obs_y = 0;
        run_until_jobs(5, 300);
        check("s4_y_beats", obs_y, 11);

        // Asynchronous reset in the middle of a load
        new_job(0, 1'b0);
        run_until_load(9, 200);
        check("s5_in_cnt_before", dut.in_cnt_q, 9);
        reset = 1'b1;
        #1;
        check_idle_outputs("s5_async");
        check("s5_in_cnt", dut.in_cnt_q, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        new_job(1, 1'b0);
        run_until_jobs(1, 200);

        // Engine talks on y during load: sticky error
        new_job(0, 1'b0);
        run_until_load(3, 100);
        force_yv = 1'b1;
        tick();
        force_yv = 1'b0;
        check("s6_err_set", protocol_err, 1);
        run_until_jobs(2, 200);
        new_job(1, 1'b0);
        run_until_jobs(3, 200);
        check("s6_err_sticky", protocol_err, 1);
        do_reset();

        // Random traffic, random handshakes
        rnd = 1'b1; traffic = 1'b1;
        run_until_jobs(12, 6000);
        rnd = 1'b0; traffic = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Shares one streaming convolution engine (x_data/x_valid/x_ready in, y_data/y_valid/y_ready out; X inputs in, X-F+1 ReLU outputs back) between N requesters.
- Grants the engine to one requester for a whole job: X input beats, then X-F+1 output beats. The grant then rotates round-robin.
- Sits between the client streams and a single conv engine instance. It never inspects data values.

Parameters:
N, 2, number of requesters (2..8)
X, 16, input vector length per job
F, 6, filter taps; output beats per job = X-F+1
W, 16, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_x_data  in  N*W  per-requester input data; requester i uses bits [i*W +: W]
req_x_valid  in  N  per-requester input valid
req_x_ready  out  N  per-requester input ready
req_y_data  out  W  output data, broadcast to all requesters
req_y_valid  out  N  per-requester output valid
req_y_ready  in  N  per-requester output ready
eng_x_data  out  W  to engine x_data
eng_x_valid  out  1  to engine x_valid
eng_x_ready  in  1  from engine x_ready
eng_y_data  in  W  from engine y_data
eng_y_valid  in  1  from engine y_valid
eng_y_ready  out  1  to engine y_ready
grant  out  N  one-hot owner of the engine; 0 when idle
busy  out  1  high in every state except IDLE
jobs_done  out  16  wrapping count of completed jobs
protocol_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; grant=0; priority pointer=0; in_cnt=0; out_cnt=0; jobs_done=0; protocol_err=0.
  - All ready/valid outputs are 0 and all data outputs are 0.
  - A reset asserted mid-job abandons the job, with no partial completion counted. The engine must be reset in the same cycle; the integration owns that.
- States: IDLE, GRANT, LOAD, UNLOAD.
- IDLE:
  - If any req_x_valid is set, pick the first set bit scanning from the pointer upward with wrap-around.
  - Register it into grant and go to GRANT. This is one cycle of arbitration latency.
  - Requests arriving in the same cycle are resolved by the pointer only.
- GRANT:
  - One-cycle settle: all readies are held at 0. Next state is LOAD.
- LOAD (owner g):
  - eng_x_valid = req_x_valid[g]; eng_x_data = owner's slice; req_x_ready[g] = eng_x_ready. All other req_x_ready are 0.
  - in_cnt increments on each eng_x_valid & eng_x_ready beat.
  - On the beat where in_cnt reaches X-1, go to UNLOAD and clear in_cnt.
  - A deasserted owner valid stalls the job. There is no timeout and no preemption.
- UNLOAD:
  - eng_x_valid=0.
  - req_y_valid[g] = eng_y_valid; req_y_data = eng_y_data; eng_y_ready = req_y_ready[g]. Other req_y_valid are 0.
  - out_cnt increments on each eng_y_valid & eng_y_ready beat.
  - On the beat where out_cnt reaches X-F:
    - jobs_done++;
    - pointer = (g+1) mod N;
    - grant=0;
    - go to IDLE.
- All forwarding is combinational from state/grant. The block adds zero data latency and no buffering.
- protocol_err is set and held until reset when:
  - eng_y_valid=1 in IDLE, GRANT or LOAD; or
  - eng_x_ready=1 in UNLOAD.
- Widths: in_cnt and out_cnt are $clog2(X) bits; the pointer is $clog2(N) bits, minimum 1.
- Invariant: grant is one-hot or zero at all times.

Decomposition:
- Package conv_sched_pkg holds:
  - the state enum (IDLE, GRANT, LOAD, UNLOAD);
  - localparams OUT_BEATS = X-F+1, CNT_W, PTR_W;
  - a function onehot_to_idx.
- Sub-module rr_pick: purely combinational (req[N], ptr) -> one-hot pick plus valid.
  - Instantiated once.
  - Separately unit-testable.

Test Plan:
1. Single requester 0, 16 beats of value 1, y_ready=1 throughout:
   - grant goes 01 one cycle after the first valid;
   - exactly 16 x beats reach the engine and 11 y beats return on req_y_valid[0];
   - jobs_done=1, grant returns to 00.
2. Both requesters valid in the same IDLE cycle after reset:
   - requester 0 is served first, then requester 1 is granted immediately afterwards (pointer=1);
   - no interleaving of beats between the two jobs.
3. Owner drops x_valid for 5 cycles at beat 7:
   - in_cnt holds at 7 and the engine sees no beats;
   - the job completes with 16 total beats;
   - requester 1 stays unserved, with req_x_ready[1]=0 throughout.
4. req_y_ready[g]=0 for 3 cycles mid-UNLOAD:
   - eng_y_ready=0 for those cycles and out_cnt holds;
   - all 11 outputs are delivered in order.
5. Reset asserted in LOAD at beat 9:
   - grant, busy, all readies, in_cnt and jobs_done drop to 0 immediately, without waiting for a clock edge;
   - the next request is granted normally.
6. Force eng_y_valid=1 during LOAD:
   - protocol_err=1 and stays set through later jobs until reset.
